// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges ALU and LSU results into one registered register-file write per cycle
module rf_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_alu_valid,
    input  logic [4:0]                 i_alu_waddr,
    input  logic [XLEN-1:0]            i_alu_wdata,
    input  logic                       i_lsu_valid,
    output logic                       o_lsu_ready,
    input  logic [4:0]                 i_lsu_waddr,
    input  logic [XLEN-1:0]            i_lsu_wdata,
    output logic                       o_rd_wen,
    output logic [4:0]                 o_rd_waddr,
    output logic [XLEN-1:0]            o_rd_wdata,
    input  logic [4:0]                 i_chk_addr,
    output logic                       o_chk_pending,
    output logic [$clog2(DEPTH):0]     o_fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      mem_a [DEPTH];
    logic [XLEN-1:0] mem_d [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            alu_req, lsu_ok, pop, push;

    // ready comes from registered occupancy only, so a pop never frees a slot in the same cycle
    assign o_lsu_ready  = i_rst_n && (count < CW'(DEPTH));
    assign alu_req      = i_alu_valid && (i_alu_waddr != 5'd0);
    assign lsu_ok       = i_lsu_valid && o_lsu_ready && (i_lsu_waddr != 5'd0);
    assign pop          = !alu_req && (count != '0);
    assign push         = lsu_ok && (alu_req || (count != '0));
    assign o_fifo_count = count;

    // WAW hazard query over live entries, skipping the head that is retiring this cycle
    always_comb begin
        o_chk_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if ((mem_a[i] == i_chk_addr) && ({1'b0, AW'(AW'(i) - rd_ptr)} < count) && !(pop && (AW'(i) == rd_ptr)))
                o_chk_pending = 1'b1;
        o_chk_pending = o_chk_pending && (i_chk_addr != 5'd0);
    end

    // FIFO storage; contents need no reset because count qualifies every entry
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_a[wr_ptr] <= i_lsu_waddr;
            mem_d[wr_ptr] <= i_lsu_wdata;
        end
    end

    // pointer bookkeeping and write-port selection: ALU, then FIFO head, then LSU bypass
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            o_rd_wen   <= 1'b0;
            o_rd_waddr <= '0;
            o_rd_wdata <= '0;
        end else begin
            rd_ptr   <= rd_ptr + AW'(pop);
            wr_ptr   <= wr_ptr + AW'(push);
            count    <= count + CW'(push) - CW'(pop);
            o_rd_wen <= alu_req || pop || lsu_ok;
            if (alu_req) begin
                o_rd_waddr <= i_alu_waddr;
                o_rd_wdata <= i_alu_wdata;
            end else if (pop) begin
                o_rd_waddr <= mem_a[rd_ptr];
                o_rd_wdata <= mem_d[rd_ptr];
            end else if (lsu_ok) begin
                o_rd_waddr <= i_lsu_waddr;
                o_rd_wdata <= i_lsu_wdata;
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: queue-model self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            i_clk = 1'b0, i_rst_n = 1'b0;
    logic            i_alu_valid = 1'b0, i_lsu_valid = 1'b0;
    logic [4:0]      i_alu_waddr = '0, i_lsu_waddr = '0, i_chk_addr = '0;
    logic [XLEN-1:0] i_alu_wdata = '0, i_lsu_wdata = '0;
    logic            o_lsu_ready, o_rd_wen, o_chk_pending;
    logic [4:0]      o_rd_waddr;
    logic [XLEN-1:0] o_rd_wdata;
    logic [2:0]      o_fifo_count;

    rf_wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_alu_valid(i_alu_valid), .i_alu_waddr(i_alu_waddr), .i_alu_wdata(i_alu_wdata),
        .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready),
        .i_lsu_waddr(i_lsu_waddr), .i_lsu_wdata(i_lsu_wdata),
        .o_rd_wen(o_rd_wen), .o_rd_waddr(o_rd_waddr), .o_rd_wdata(o_rd_wdata),
        .i_chk_addr(i_chk_addr), .o_chk_pending(o_chk_pending), .o_fifo_count(o_fifo_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [4:0]      a;
        logic [XLEN-1:0] d;
    } ent_t;

    ent_t            q[$];
    logic            m_wen  = 1'b0;
    logic [4:0]      m_addr = '0;
    logic [XLEN-1:0] m_data = '0;
    int              n_chk  = 0;
    int              n_fail = 0;
    bit              acc_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock: compare DUT against the model at the falling edge, then advance the model
    task automatic cycle();
        bit   alu_req, acc, lsu_nz, pop, pend;
        ent_t e;
        @(negedge i_clk);
        alu_req = i_alu_valid && i_alu_waddr != 0;
        acc     = i_lsu_valid && q.size() < DEPTH;
        lsu_nz  = acc && i_lsu_waddr != 0;
        pop     = !alu_req && q.size() > 0;
        pend    = 0;
        foreach (q[i])
            if (i_chk_addr != 0 && q[i].a == i_chk_addr && !(pop && i == 0)) pend = 1;
        check("rd_wen", 64'(o_rd_wen), 64'(m_wen));
        check("rd_waddr", 64'(o_rd_waddr), 64'(m_addr));
        check("rd_wdata", 64'(o_rd_wdata), 64'(m_data));
        check("fifo_count", 64'(o_fifo_count), 64'(q.size()));
        check("lsu_ready", 64'(o_lsu_ready), 64'(q.size() < DEPTH));
        check("chk_pending", 64'(o_chk_pending), 64'(pend));
        acc_last = acc;
        e.a = i_lsu_waddr;
        e.d = i_lsu_wdata;
        if (alu_req) begin
            m_wen = 1; m_addr = i_alu_waddr; m_data = i_alu_wdata;
            if (lsu_nz) q.push_back(e);
        end else if (pop) begin
            ent_t h;
            h = q.pop_front();
            m_wen = 1; m_addr = h.a; m_data = h.d;
            if (lsu_nz) q.push_back(e);
        end else if (lsu_nz) begin
            m_wen = 1; m_addr = i_lsu_waddr; m_data = i_lsu_wdata;
        end else
            m_wen = 0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_alu_valid = 0; i_alu_waddr = 0; i_alu_wdata = 0;
        i_lsu_valid = 0; i_lsu_waddr = 0; i_lsu_wdata = 0;
    endtask

    logic [4:0]      lsu_a [5] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
    logic [XLEN-1:0] lsu_d [5] = '{32'hCAFEBABE, 32'h12345678, 32'h0000C0DE, 32'h0BADF00D, 32'h14141414};
    logic [4:0]      seen_a [$];
    logic [XLEN-1:0] seen_d [$];

    initial begin
        int k;
        #3;
        check("reset_wen", 64'(o_rd_wen), 64'd0);
        check("reset_ready", 64'(o_lsu_ready), 64'd0);
        check("reset_count", 64'(o_fifo_count), 64'd0);
        #9 i_rst_n = 1;
        @(posedge i_clk);
        #1;
        cycle();

        // single ALU write
        i_alu_valid = 1; i_alu_waddr = 5; i_alu_wdata = 32'hDEADBEEF;
        cycle();
        idle_inputs();
        check("alu_wen_lit", 64'(o_rd_wen), 64'd1);
        check("alu_data_lit", 64'(o_rd_wdata), 64'hDEADBEEF);
        cycle();
        check("alu_wen_off_lit", 64'(o_rd_wen), 64'd0);

        // x0 filter on both sources
        i_alu_valid = 1; i_alu_waddr = 0; i_alu_wdata = 32'hFFFFFFFF;
        i_lsu_valid = 1; i_lsu_waddr = 0; i_lsu_wdata = 32'h55555555;
        cycle();
        check("x0_lsu_accepted", 64'(acc_last), 64'd1);
        idle_inputs();
        check("x0_wen_lit", 64'(o_rd_wen), 64'd0);
        check("x0_count_lit", 64'(o_fifo_count), 64'd0);
        cycle();

        // ALU contention fills the FIFO; pending queries ride along
        k = 0;
        for (int i = 0; i < 6; i++) begin
            i_alu_valid = 1; i_alu_waddr = 5'(i + 1); i_alu_wdata = 32'h11 * (i + 1);
            i_lsu_valid = k < 5;
            i_lsu_waddr = lsu_a[k < 5 ? k : 4];
            i_lsu_wdata = lsu_d[k < 5 ? k : 4];
            i_chk_addr  = i == 2 ? 5'd11 : i == 3 ? 5'd0 : 5'd10;
            if (i == 1) begin
                #1;
                check("pending_x10_lit", 64'(o_chk_pending), 64'd1);
            end
            cycle();
            if (acc_last) k++;
            if (i == 3) begin
                check("full_count_lit", 64'(o_fifo_count), 64'd4);
                check("full_ready_lit", 64'(o_lsu_ready), 64'd0);
            end
        end
        check("x14_held_lit", 64'(k), 64'd4);

        // drain: five LSU writes back to back in acceptance order
        i_alu_valid = 0; i_alu_waddr = 0;
        i_chk_addr = 10;
        for (int i = 0; i < 8; i++) begin
            i_lsu_valid = k < 5;
            i_lsu_waddr = lsu_a[k < 5 ? k : 4];
            i_lsu_wdata = lsu_d[k < 5 ? k : 4];
            cycle();
            if (acc_last) k++;
            if (o_rd_wen) begin
                seen_a.push_back(o_rd_waddr);
                seen_d.push_back(o_rd_wdata);
            end
        end
        idle_inputs();
        check("drain_writes_lit", 64'(seen_a.size()), 64'd5);
        for (int i = 0; i < 5 && i < seen_a.size(); i++)
            check("drain_addr_lit", 64'(seen_a[i]), 64'(10 + i));
        if (seen_d.size() >= 2) begin
            check("drain_x10_data_lit", 64'(seen_d[0]), 64'hCAFEBABE);
            check("drain_x11_data_lit", 64'(seen_d[1]), 64'h12345678);
        end
        #1;
        check("pending_after_pop_lit", 64'(o_chk_pending), 64'd0);
        cycle();

        // bypass when idle and empty
        i_lsu_valid = 1; i_lsu_waddr = 7; i_lsu_wdata = 32'hA5A5A5A5;
        cycle();
        idle_inputs();
        check("bypass_wen_lit", 64'(o_rd_wen), 64'd1);
        check("bypass_addr_lit", 64'(o_rd_waddr), 64'd7);
        check("bypass_count_lit", 64'(o_fifo_count), 64'd0);
        cycle();

        // asynchronous reset with two entries queued
        for (int i = 0; i < 2; i++) begin
            i_alu_valid = 1; i_alu_waddr = 5'(i + 1); i_alu_wdata = 32'h100 + i;
            i_lsu_valid = 1; i_lsu_waddr = 5'(20 + i); i_lsu_wdata = 32'h200 + i;
            cycle();
        end
        idle_inputs();
        check("pre_reset_count_lit", 64'(o_fifo_count), 64'd2);
        #2 i_rst_n = 0;
        #1;
        check("async_wen_lit", 64'(o_rd_wen), 64'd0);
        check("async_count_lit", 64'(o_fifo_count), 64'd0);
        check("async_ready_lit", 64'(o_lsu_ready), 64'd0);
        q.delete();
        m_wen = 0; m_addr = 0; m_data = 0;
        @(posedge i_clk);
        #3 i_rst_n = 1;
        #1;
        check("release_ready_lit", 64'(o_lsu_ready), 64'd1);
        for (int i = 0; i < 3; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
